// File: rtl/split_candidate_sampler.sv
// Pseudo-random candidate generator for the split constraint checkers: xorshift lanes feed a
// registered candidate, retried until every split passes or the try budget runs out.

module split_candidate_sampler_lane #(
  parameter logic [31:0] RST_VAL = 32'h1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        adv,
  input  logic [31:0] load_val,
  output logic [31:0] nxt
);
  logic [31:0] lane_q, lane_d;
  logic [31:0] s0, s1;

  always_comb begin
    s0  = lane_q ^ (lane_q << 13);
    s1  = s0 ^ (s0 >> 17);
    nxt = s1 ^ (s1 << 5);
  end

  // Zero is the xorshift fixed point, so a zero load is forced to 1.
  always_comb begin
    lane_d = lane_q;
    if (load)     lane_d = (load_val == 32'h0) ? 32'h1 : load_val;
    else if (adv) lane_d = nxt;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lane_q <= RST_VAL;
    else        lane_q <= lane_d;
endmodule

module split_candidate_sampler #(
  parameter int NUM_SPLITS = 4,
  parameter int VEC_W      = 256,
  parameter int MAX_TRIES  = 1024,
  parameter int TRY_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  seed_load,
  input  logic [31:0]           seed,
  output logic [VEC_W-1:0]      cand,
  input  logic [NUM_SPLITS-1:0] split_ok,
  output logic                  sol_valid,
  input  logic                  sol_ready,
  output logic [VEC_W-1:0]      sol_data,
  output logic [TRY_W-1:0]      sol_tries,
  output logic                  busy,
  output logic                  fail
);
  localparam int NUM_LANES = VEC_W / 32;
  localparam logic [31:0] GOLDEN = 32'h9E3779B9;

  typedef enum logic [2:0] {S_IDLE, S_GEN, S_CHECK, S_HOLD, S_FAIL} state_t;

  state_t                         state_q, state_d;
  logic [VEC_W-1:0]               cand_q, cand_d;
  logic [VEC_W-1:0]               sol_data_q, sol_data_d;
  logic [TRY_W-1:0]               try_q, try_d;
  logic [TRY_W-1:0]               sol_tries_q, sol_tries_d;
  logic                           sol_valid_q, sol_valid_d;
  logic                           lane_load, lane_adv;
  logic [NUM_LANES-1:0][31:0]     lanes_nxt;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic [31:0] OFS = 32'(i) * GOLDEN;
    split_candidate_sampler_lane #(.RST_VAL(32'h1 + OFS)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (lane_load),
      .adv      (lane_adv),
      .load_val (seed + OFS),
      .nxt      (lanes_nxt[i])
    );
  end

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    try_d       = try_q;
    sol_valid_d = sol_valid_q;
    sol_data_d  = sol_data_q;
    sol_tries_d = sol_tries_q;
    lane_load   = 1'b0;
    lane_adv    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (seed_load) lane_load = 1'b1;
        else if (start) begin
          state_d = S_GEN;
          try_d   = '0;
        end
      end
      S_GEN: begin
        lane_adv = 1'b1;
        cand_d   = lanes_nxt;
        try_d    = try_q + 1'b1;
        state_d  = S_CHECK;
      end
      S_CHECK: begin
        if (&split_ok) begin
          state_d     = S_HOLD;
          sol_valid_d = 1'b1;
          sol_data_d  = cand_q;
          sol_tries_d = try_q;
        end else if (try_q == TRY_W'(MAX_TRIES)) state_d = S_FAIL;
        else                                     state_d = S_GEN;
      end
      S_HOLD: begin
        if (sol_ready) begin
          sol_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cand_q      <= '0;
      try_q       <= '0;
      sol_valid_q <= 1'b0;
      sol_data_q  <= '0;
      sol_tries_q <= '0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      try_q       <= try_d;
      sol_valid_q <= sol_valid_d;
      sol_data_q  <= sol_data_d;
      sol_tries_q <= sol_tries_d;
    end

  assign cand      = cand_q;
  assign sol_valid = sol_valid_q;
  assign sol_data  = sol_data_q;
  assign sol_tries = sol_tries_q;
  assign busy      = (state_q == S_GEN) || (state_q == S_CHECK);
  assign fail      = (state_q == S_FAIL);
endmodule

// File: tb/tb_split_candidate_sampler.sv
// Directed bench for split_candidate_sampler (2 lanes, try budget 8) with a reference xorshift model.

module tb_split_candidate_sampler;
  localparam int VW = 64;
  localparam logic [31:0] G = 32'h9E3779B9;

  logic          clk = 1'b0;
  logic          rst_n, start, seed_load, sol_ready;
  logic [31:0]   seed;
  logic [VW-1:0] cand, sol_data, pass_cand;
  logic [3:0]    split_ok;
  logic          sol_valid, busy, fail;
  logic [15:0]   sol_tries;
  int            mode;
  int            n_assert = 0, n_fail = 0;
  logic [31:0]   m[2];

  split_candidate_sampler #(.NUM_SPLITS(4), .VEC_W(VW), .MAX_TRIES(8), .TRY_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed_load(seed_load), .seed(seed),
    .cand(cand), .split_ok(split_ok), .sol_valid(sol_valid), .sol_ready(sol_ready),
    .sol_data(sol_data), .sol_tries(sol_tries), .busy(busy), .fail(fail)
  );

  always #5 clk = ~clk;

  // mode 0: every candidate passes; 1: none pass; 2: only pass_cand passes (one split vetoes others)
  assign split_ok = (mode == 0) ? 4'hF : (mode == 1) ? 4'h0 : ((cand == pass_cand) ? 4'hF : 4'h7);

  function automatic logic [31:0] xs(input logic [31:0] x);
    x ^= x << 13;
    x ^= x >> 17;
    x ^= x << 5;
    return x;
  endfunction

  task automatic adv_model();
    m[0] = xs(m[0]);
    m[1] = xs(m[1]);
  endtask

  task automatic load_model(input logic [31:0] s);
    m[0] = (s == 32'h0) ? 32'h1 : s;
    m[1] = ((s + G) == 32'h0) ? 32'h1 : s + G;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int fcnt, fidx, vcnt, lat, unstable;
    logic [VW-1:0] held;
    rst_n = 1'b0; start = 1'b0; seed_load = 1'b0; sol_ready = 1'b0; seed = '0;
    mode = 0; pass_cand = '0;
    m[0] = 32'h1; m[1] = 32'h1 + G;
    tick(2);
    chk("rst_cand", cand, 0);
    chk("rst_valid", sol_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fail", fail, 0);
    chk("rst_data", sol_data, 0);
    chk("rst_tries", sol_tries, 0);
    rst_n = 1'b1;
    tick(1);

    // 1: first-try pass from seed 1
    seed_load = 1'b1; seed = 32'h1; tick(1); seed_load = 1'b0; load_model(32'h1);
    start = 1'b1; tick(1); start = 1'b0;
    chk("t1_busy_gen", busy, 1);
    tick(1); adv_model();
    chk("t1_cand", cand, {m[1], m[0]});
    chk("t1_valid_early", sol_valid, 0);
    tick(1);
    chk("t1_valid", sol_valid, 1);
    chk("t1_tries", sol_tries, 1);
    chk("t1_data", sol_data, {m[1], m[0]});
    chk("t1_busy_hold", busy, 0);
    sol_ready = 1'b1; tick(1); sol_ready = 1'b0;
    chk("t1_valid_drop", sol_valid, 0);

    // 2: nothing passes, budget of 8 exhausts
    mode = 1; start = 1'b1; fcnt = 0; fidx = 0; vcnt = 0;
    for (int i = 1; i <= 18; i++) begin
      tick(1); start = 1'b0;
      if (fail) begin fcnt++; fidx = i; end
      if (sol_valid) vcnt++;
    end
    repeat (8) adv_model();
    chk("t2_fail_cnt", fcnt, 1);
    chk("t2_fail_cycle", fidx, 17);
    chk("t2_no_valid", vcnt, 0);
    chk("t2_busy", busy, 0);
    chk("t2_cand", cand, {m[1], m[0]});

    // 3: pass on the 5th candidate
    repeat (5) adv_model();
    pass_cand = {m[1], m[0]};
    mode = 2; start = 1'b1; lat = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      tick(1); start = 1'b0;
      if (sol_valid) lat = i;
    end
    chk("t3_latency", lat, 11);
    chk("t3_tries", sol_tries, 5);
    chk("t3_data", sol_data, pass_cand);

    // 4: stall in HOLD with start pulsing; outputs must not move
    held = sol_data; unstable = 0; start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (!sol_valid || sol_data !== held || busy || cand !== held) unstable++;
    end
    start = 1'b0;
    chk("t4_stable", unstable, 0);
    sol_ready = 1'b1; tick(1); sol_ready = 1'b0;
    chk("t4_valid_drop", sol_valid, 0);
    tick(1);
    chk("t4_idle", busy, 0);

    // 5: zero seed maps to 1; seed_load beats start
    mode = 0; seed_load = 1'b1; seed = 32'h0; tick(1); seed_load = 1'b0; load_model(32'h0);
    start = 1'b1; tick(1); start = 1'b0; tick(2); adv_model();
    chk("t5_zero_seed", sol_data, {m[1], m[0]});
    chk("t5_lane0", sol_data[31:0], 32'h0004_2021);
    sol_ready = 1'b1; tick(1); sol_ready = 1'b0;
    seed_load = 1'b1; start = 1'b1; seed = 32'h1234_5678; tick(1);
    seed_load = 1'b0; start = 1'b0; load_model(32'h1234_5678);
    chk("t5_no_gen", busy, 0);
    tick(1);
    chk("t5_still_idle", busy, 0);
    start = 1'b1; tick(1); start = 1'b0; tick(2); adv_model();
    chk("t5_new_seed", sol_data, {m[1], m[0]});
    sol_ready = 1'b1; tick(1); sol_ready = 1'b0;

    // 6: async reset mid-CHECK, then a clean start
    mode = 1; start = 1'b1; tick(1); start = 1'b0; tick(1);
    chk("t6_in_check", busy, 1);
    rst_n = 1'b0; #1;
    chk("t6_rst_cand", cand, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_valid", sol_valid, 0);
    chk("t6_rst_fail", fail, 0);
    chk("t6_rst_data", sol_data, 0);
    #2 rst_n = 1'b1;
    m[0] = 32'h1; m[1] = 32'h1 + G; mode = 0;
    tick(1);
    start = 1'b1; tick(1); start = 1'b0; tick(2); adv_model();
    chk("t6_valid", sol_valid, 1);
    chk("t6_tries", sol_tries, 1);
    chk("t6_data", sol_data, {m[1], m[0]});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
